// File: rtl/decry_stream_loader.sv
// Byte-stream front end for the combinational AES-128 decryptor: gathers key and
// ciphertext bytes, waits for the decryptor to settle, then holds the plaintext on a valid/ready port.
module decry_stream_loader #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_is_key,
  output logic         in_ready,
  output logic [0:127] encr_data,
  output logic [0:127] key,
  input  logic [0:127] decryp_data,
  output logic [0:127] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         key_loaded,
  output logic         drop_pulse,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Handshake: a byte moves on a rising edge where in_valid & in_ready; a result
  // moves on a rising edge where out_valid & out_ready. Neither ready depends on its valid.

  logic [1:0]   r_state;
  logic [0:127] r_key;
  logic [0:127] r_data;
  logic [0:127] r_out;
  logic [3:0]   r_key_cnt;
  logic [3:0]   r_data_cnt;
  logic [3:0]   r_settle_cnt;
  logic         r_key_loaded;
  logic         r_out_valid;
  logic         r_drop;
  logic         w_accept;
  logic [6:0]   w_key_base;
  logic [6:0]   w_data_base;

  assign in_ready    = rst_n & (r_state == ST_LOAD);
  assign w_accept    = in_valid & in_ready;
  assign w_key_base  = {r_key_cnt, 3'b000};
  assign w_data_base = {r_data_cnt, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_LOAD;
      r_key        <= '0;
      r_data       <= '0;
      r_out        <= '0;
      r_key_cnt    <= '0;
      r_data_cnt   <= '0;
      r_settle_cnt <= '0;
      r_key_loaded <= 1'b0;
      r_out_valid  <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            if (in_is_key) begin
              // The key may only change between ciphertext blocks.
              if (r_data_cnt == 4'd0) begin
                r_key[w_key_base +: 8] <= in_byte;
                r_key_cnt              <= r_key_cnt + 4'd1;
                r_key_loaded           <= (r_key_cnt == 4'd15);
              end else begin
                r_drop <= 1'b1;
              end
            end else if (!r_key_loaded) begin
              r_drop <= 1'b1;
            end else begin
              r_data[w_data_base +: 8] <= in_byte;
              r_data_cnt               <= r_data_cnt + 4'd1;
              if (r_data_cnt == 4'd15) begin
                r_settle_cnt <= 4'(SETTLE_CYCLES);
                r_state      <= ST_SETTLE;
              end
            end
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt != 4'd0) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end else begin
            r_out       <= decryp_data;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_LOAD;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign encr_data  = r_data;
  assign key        = r_key;
  assign out_data   = r_out;
  assign out_valid  = r_out_valid;
  assign key_loaded = r_key_loaded;
  assign drop_pulse = r_drop;
  assign busy       = (r_state != ST_LOAD);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_decry_stream_loader.sv
// Bench for decry_stream_loader: two instances (settle 2 and settle 0) beside a
// transaction-level model, with a stand-in decryptor that knows the FIPS-197 vector.
module tb_decry_stream_loader;

  localparam logic [0:127] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] KAT_PT  = 128'h00112233445566778899aabbccddeeff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   in_byte = '0;
  logic         in_is_key = 1'b0;
  logic [1:0]   iv = '0;
  logic [1:0]   ordy = 2'b11;
  logic [1:0]   rdy_w, ov_w, kl_w, dp_w, busy_w;
  logic [0:127] key_w[2];
  logic [0:127] encr_w[2];
  logic [0:127] dec_w[2];
  logic [0:127] out_w[2];
  logic [1:0]   st_w[2];

  int n_checks = 0;
  int n_err = 0;

  // Stand-in decryptor: exact answer for the FIPS-197 vector, a cheap bijection otherwise.
  function automatic logic [0:127] fake_dec(input logic [0:127] k, input logic [0:127] c);
    if (k == KAT_KEY && c == KAT_CT) return KAT_PT;
    return k ^ {c[64:127], c[0:63]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  always_comb begin
    dec_w[0] = fake_dec(key_w[0], encr_w[0]);
    dec_w[1] = fake_dec(key_w[1], encr_w[1]);
  end

  decry_stream_loader #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(iv[0]), .in_is_key(in_is_key),
    .in_ready(rdy_w[0]), .encr_data(encr_w[0]), .key(key_w[0]), .decryp_data(dec_w[0]),
    .out_data(out_w[0]), .out_valid(ov_w[0]), .out_ready(ordy[0]), .key_loaded(kl_w[0]),
    .drop_pulse(dp_w[0]), .busy(busy_w[0]), .dbg_state(st_w[0]));

  decry_stream_loader #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(iv[1]), .in_is_key(in_is_key),
    .in_ready(rdy_w[1]), .encr_data(encr_w[1]), .key(key_w[1]), .decryp_data(dec_w[1]),
    .out_data(out_w[1]), .out_valid(ov_w[1]), .out_ready(ordy[1]), .key_loaded(kl_w[1]),
    .drop_pulse(dp_w[1]), .busy(busy_w[1]), .dbg_state(st_w[1]));

  task automatic chk(input string name, input int inst, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s inst%0d at %0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s timeout at %0t: got no event expected event within budget", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]   m_kb[2][16];
  logic [7:0]   m_db[2][16];
  int           m_kn[2], m_dn[2], m_left[2];
  logic         m_kl[2], m_hold[2], m_drop[2];
  logic [0:127] m_out[2];
  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [0:127] pack_key(input int i);
    logic [0:127] v = '0;
    for (int j = 0; j < 16; j++) v = {v[8:127], m_kb[i][j]};
    return v;
  endfunction

  function automatic logic [0:127] pack_dat(input int i);
    logic [0:127] v = '0;
    for (int j = 0; j < 16; j++) v = {v[8:127], m_db[i][j]};
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) begin
        m_kb[i][j] = '0;
        m_db[i][j] = '0;
      end
      m_kn[i] = 0; m_dn[i] = 0; m_left[i] = -1;
      m_kl[i] = 0; m_hold[i] = 0; m_drop[i] = 0; m_out[i] = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // m_left >= 0 means a block is waiting that many more edges before capture.
  task automatic model_step(input int i);
    m_drop[i] = 0;
    if (m_hold[i]) begin
      if (ordy[i]) m_hold[i] = 0;
    end else if (m_left[i] >= 0) begin
      if (m_left[i] == 0) begin
        m_out[i]  = fake_dec(pack_key(i), pack_dat(i));
        m_hold[i] = 1;
        m_left[i] = -1;
        if (i == 0) exp_q0.push_back(m_out[i]); else exp_q1.push_back(m_out[i]);
      end else begin
        m_left[i]--;
      end
    end else if (iv[i]) begin
      if (in_is_key) begin
        if (m_dn[i] == 0) begin
          m_kb[i][m_kn[i]] = in_byte;
          m_kn[i]++;
          m_kl[i] = 0;
          if (m_kn[i] == 16) begin m_kn[i] = 0; m_kl[i] = 1; end
        end else m_drop[i] = 1;
      end else if (!m_kl[i]) begin
        m_drop[i] = 1;
      end else begin
        m_db[i][m_dn[i]] = in_byte;
        m_dn[i]++;
        if (m_dn[i] == 16) begin m_dn[i] = 0; m_left[i] = settle_of(i); end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic busy_m;
      logic [127:0] e;
      busy_m = m_hold[i] || (m_left[i] >= 0);
      chk("in_ready",   i, 128'(rdy_w[i]),  128'(rst_n && !busy_m));
      chk("busy",       i, 128'(busy_w[i]), 128'(busy_m));
      chk("out_valid",  i, 128'(ov_w[i]),   128'(m_hold[i]));
      chk("key_loaded", i, 128'(kl_w[i]),   128'(m_kl[i]));
      chk("drop_pulse", i, 128'(dp_w[i]),   128'(m_drop[i]));
      chk("key",        i, key_w[i],        pack_key(i));
      chk("encr_data",  i, encr_w[i],       pack_dat(i));
      chk("out_data",   i, out_w[i],        m_out[i]);
      chk("dbg_state",  i, 128'(st_w[i] != 2'd0), 128'(busy_m));
      if (rst_n && m_hold[i] && ordy[i]) begin
        if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) timeout("exp_q_empty");
        else begin
          e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk("handshake_data", i, out_w[i], e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int sel, input logic [7:0] b, input logic k);
    int t = 0;
    while (rdy_w[sel] !== 1'b1 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) timeout("send");
    in_byte = b; in_is_key = k; iv[sel] = 1'b1;
    @(posedge clk); #1;
    iv = '0;
  endtask

  task automatic send_field(input int sel, input logic [0:127] f, input logic k);
    logic [0:127] v;
    v = f;
    for (int n = 0; n < 16; n++) send(sel, v[8*n +: 8], k);
  endtask

  task automatic wait_valid(input int sel, output int cyc);
    cyc = 0;
    while (ov_w[sel] !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 100) timeout("wait_valid");
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    logic [0:127] ct2, v;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 0, 128'(rdy_w[0]), 128'd0);
    chk("rst_out_valid", 0, 128'(ov_w[0]), 128'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 0, 128'(rdy_w[0]), 128'd1);
    chk("rel_key", 0, key_w[0], 128'd0);

    // 1: known answer with settle 2
    send_field(0, KAT_KEY, 1'b1);
    chk("s1_key_loaded", 0, 128'(kl_w[0]), 128'd1);
    send_field(0, KAT_CT, 1'b0);
    wait_valid(0, cyc);
    chk("s1_latency", 0, 128'(cyc), 128'd3);
    chk("s1_plain", 0, out_w[0], KAT_PT);
    @(posedge clk); #1;
    chk("s1_valid_drop", 0, 128'(ov_w[0]), 128'd0);
    chk("s1_in_ready", 0, 128'(rdy_w[0]), 128'd1);

    // 2: backpressure on the same key
    ordy[0] = 1'b0;
    send_field(0, KAT_CT, 1'b0);
    wait_valid(0, cyc);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("s2_hold_valid", 0, 128'(ov_w[0]), 128'd1);
      chk("s2_hold_data", 0, out_w[0], KAT_PT);
      chk("s2_hold_ready", 0, 128'(rdy_w[0]), 128'd0);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("s2_release", 0, 128'(ov_w[0]), 128'd0);

    // 3: ciphertext with no key
    pulse_reset();
    for (int n = 0; n < 4; n++) begin
      send(0, 8'($urandom_range(0, 255)), 1'b0);
      chk("s3_drop", 0, 128'(dp_w[0]), 128'd1);
    end
    chk("s3_encr", 0, encr_w[0], 128'd0);
    chk("s3_no_valid", 0, 128'(ov_w[0]), 128'd0);

    // 4: stray key byte in the middle of a block
    send_field(0, KAT_KEY, 1'b1);
    v = KAT_CT;
    for (int n = 0; n < 5; n++) send(0, v[8*n +: 8], 1'b0);
    send(0, 8'hff, 1'b1);
    chk("s4_drop", 0, 128'(dp_w[0]), 128'd1);
    for (int n = 5; n < 16; n++) send(0, v[8*n +: 8], 1'b0);
    wait_valid(0, cyc);
    chk("s4_plain", 0, out_w[0], KAT_PT);
    chk("s4_key", 0, key_w[0], KAT_KEY);
    @(posedge clk); #1;

    // 5: reset two cycles into SETTLE
    send_field(0, KAT_CT, 1'b0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("s5_key0", 0, key_w[0], 128'd0);
    chk("s5_encr0", 0, encr_w[0], 128'd0);
    chk("s5_out0", 0, out_w[0], 128'd0);
    chk("s5_flags0", 0, 128'({ov_w[0], kl_w[0], dp_w[0], busy_w[0], rdy_w[0]}), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("s5_kl", 0, 128'(kl_w[0]), 128'd0);
    chk("s5_ready", 0, 128'(rdy_w[0]), 128'd1);
    send_field(0, KAT_KEY, 1'b1);
    send_field(0, KAT_CT, 1'b0);
    wait_valid(0, cyc);
    chk("s5_plain", 0, out_w[0], KAT_PT);
    @(posedge clk); #1;

    // 6: settle 0, two blocks on one key
    pulse_reset();
    send_field(1, KAT_KEY, 1'b1);
    send_field(1, KAT_CT, 1'b0);
    wait_valid(1, cyc);
    chk("s6_latency_a", 1, 128'(cyc), 128'd1);
    chk("s6_plain_a", 1, out_w[1], KAT_PT);
    @(posedge clk); #1;
    ct2 = {$urandom, $urandom, $urandom, $urandom};
    send_field(1, ct2, 1'b0);
    wait_valid(1, cyc);
    chk("s6_latency_b", 1, 128'(cyc), 128'd1);
    chk("s6_plain_b", 1, out_w[1], fake_dec(KAT_KEY, ct2));
    @(posedge clk); #1;

    // random traffic on both instances
    for (int c = 0; c < 4000; c++) begin
      iv[0] = ($urandom_range(0, 3) != 0);
      iv[1] = ($urandom_range(0, 3) != 0);
      in_byte = 8'($urandom_range(0, 255));
      in_is_key = (c < 1500) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 19) == 0);
      ordy[0] = ($urandom_range(0, 1) != 0);
      ordy[1] = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 899) != 0);
      @(posedge clk); #1;
    end
    iv = '0; ordy = 2'b11; rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/decry_stream_loader.md
Name: decry_stream_loader

Overview:
Upstream front-end for the combinational AES-128 decryptor `main_decry`.
- Assembles an 8-bit byte stream into 128-bit key and ciphertext registers and drives them onto the decryptor's `key` / `encr_data` inputs.
- Waits a programmable settle time, then captures `decryp_data` into an output register.
- Returns the result on a valid/ready handshake, turning the untimed decryptor into a clocked, flow-controlled stage.

Parameters:
SETTLE_CYCLES, 2, extra wait cycles after the last ciphertext byte before `decryp_data` is captured (legal 0..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_byte  in  8  stream byte
- in_valid  in  1  in_byte valid
- in_is_key  in  1  1 = byte belongs to key, 0 = byte belongs to ciphertext
- in_ready  out  1  block accepts a byte this cycle
- encr_data  out  [0:127]  ciphertext register, to the decryptor's encr_data
- key  out  [0:127]  key register, to the decryptor's key
- decryp_data  in  [0:127]  decryptor result
- out_data  out  [0:127]  captured plaintext
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- key_loaded  out  1  all 16 key bytes present
- drop_pulse  out  1  one-cycle pulse when an accepted-handshake byte is discarded
- busy  out  1  high in SETTLE or HOLD

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = LOAD.
  - encr_data, key, out_data = 0.
  - key_cnt, data_cnt, settle_cnt = 0.
  - key_loaded, out_valid, drop_pulse = 0.
  - in_ready = 0 while rst_n low.
  - Reset mid-operation discards partial blocks, the loaded key and any pending output.
- Byte order: the n-th byte of a field (n = 0..15) occupies bits [8n:8n+7]. Byte 0 is the first received and sits in the MSB end.
- Handshake: a byte transfers on a rising edge with in_valid & in_ready. in_ready = rst_n & (state == LOAD), purely state-based and independent of in_is_key.
- State LOAD:
  - Key byte, data_cnt == 0: write key byte key_cnt and increment key_cnt.
    - If key_loaded was 1, clear it (reload started).
    - On the 16th byte: key_cnt wraps to 0 and key_loaded = 1.
  - Key byte, data_cnt != 0: discard the byte and pulse drop_pulse; no key change mid-block.
  - Data byte, key_loaded == 0: discard the byte and pulse drop_pulse.
  - Data byte, key_loaded == 1: write encr_data byte data_cnt and increment data_cnt.
    - On the 16th byte: data_cnt wraps to 0, settle_cnt = SETTLE_CYCLES, next state SETTLE.
- State SETTLE:
  - in_ready = 0; encr_data and key are held stable.
  - If settle_cnt != 0, decrement it.
  - If settle_cnt == 0: out_data <= decryp_data, out_valid <= 1, next state HOLD.
  - Latency: out_valid rises exactly SETTLE_CYCLES+1 cycles after the edge that accepted the 16th ciphertext byte.
- State HOLD:
  - out_valid = 1 and out_data is stable.
  - On an edge with out_ready = 1: out_valid <= 0, next state LOAD. in_ready returns the following cycle.
  - out_ready is ignored outside HOLD.
  - Output persists indefinitely under backpressure.
- Key persists across blocks: after one key load, any number of 16-byte ciphertext blocks may follow without reloading.
- drop_pulse is registered: high for exactly the cycle after the discarded transfer.
- busy = (state != LOAD).
- No input overlap with HOLD: the next block cannot start until the result is consumed. Throughput is at most 1 block per 16 + SETTLE_CYCLES + 2 cycles.

Test Plan:
1. FIPS-197 AES-128 known answer (SETTLE_CYCLES = 2):
   - Stimulus: key bytes 00 01 .. 0f, then ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with out_ready = 1.
   - Required: key_loaded = 1 after the 16th key byte; out_valid rises 3 cycles after the last ciphertext byte; out_data = 00112233445566778899aabbccddeeff; out_valid drops one cycle later; in_ready returns to 1.
2. Backpressure:
   - Stimulus: as scenario 1 with out_ready = 0 for 20 cycles.
   - Required: out_valid stays 1, out_data unchanged, in_ready = 0 throughout; release on out_ready = 1 within 1 edge.
3. No key:
   - Stimulus: 4 ciphertext bytes sent after reset.
   - Required: 4 drop_pulse cycles, data_cnt stays 0, encr_data = 0, no out_valid.
4. Key during block:
   - Stimulus: after a valid key, send 5 ciphertext bytes, one key byte ff, then the remaining 11 ciphertext bytes.
   - Required: one drop_pulse, key unchanged, correct plaintext produced.
5. Reset mid-SETTLE:
   - Stimulus: assert rst_n = 0 asynchronously two cycles into SETTLE.
   - Required: all outputs 0 immediately; after release, key_loaded = 0, in_ready = 1, and a full reload reproduces the scenario 1 result.
6. Key reuse and SETTLE_CYCLES = 0:
   - Stimulus: two consecutive ciphertext blocks on one key.
   - Required: both plaintexts correct; out_valid rises 1 cycle after each block's last byte.
